hit_centroid_ctrl: RTL and testbench

- Per-frame scheduler for the colour-detection path.
- Consumes the 1-bit per-pixel hit from a colour classifier, in step with the VGA read timing (data-enable = pixel request, active-low vertical sync).
- Accumulates hit count and coordinate sums over the active 640x480 window. At each vertical sync it snapshots them and runs a shared sequential divider to produce the hit centroid.
- Presents the centroid to the downstream cursor/mouse logic via valid/ready.

---
 rtl/hit_ctrl_pkg.sv | 25 ++
 rtl/seq_udiv.sv | 66 ++++++
 rtl/hit_centroid_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hit_centroid_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_ctrl_pkg.sv
// Shared definitions for the hit centroid controller: FSM states,
// default window geometry, datapath widths and detection threshold.
package hit_ctrl_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_X_W      = 10;
  localparam int unsigned DEF_Y_W      = 9;
  localparam int unsigned DEF_CNT_W    = 19;
  localparam int unsigned DEF_SUM_W    = 29;
  localparam int unsigned DEF_MIN_HITS = 64;

  typedef enum logic [2:0] {
    ACCUM,
    LATCH,
    DIV_X,
    DIV_Y,
    PRESENT
  } ctrl_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle MSB first.
// The first bit is resolved on the start cycle, so done pulses exactly DVD_W cycles after start.
module seq_udiv #(
  parameter int unsigned DVD_W = 29,
  parameter int unsigned DVS_W = 19,
  parameter int unsigned Q_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int unsigned IW = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] dvd, dvd_src, dvd_next;
  logic [DVS_W-1:0] rem, rem_src, rem_next, dvs, dvs_src;
  logic [DVS_W:0]   trial;
  logic             ge;
  logic [IW-1:0]    iter;
  logic             active;

  always_comb begin
    dvd_src  = start ? dividend : dvd;
    rem_src  = start ? '0 : rem;
    dvs_src  = start ? divisor : dvs;
    trial    = {rem_src, dvd_src[DVD_W-1]};
    ge       = trial >= {1'b0, dvs_src};
    rem_next = ge ? DVS_W'(trial - {1'b0, dvs_src}) : trial[DVS_W-1:0];
    dvd_next = {dvd_src[DVD_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd    <= '0;
      rem    <= '0;
      dvs    <= '0;
      iter   <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dvd    <= dvd_next;
        rem    <= rem_next;
        dvs    <= divisor;
        iter   <= IW'(DVD_W - 1);
        active <= 1'b1;
      end else if (active) begin
        dvd  <= dvd_next;
        rem  <= rem_next;
        iter <= iter - IW'(1);
        if (iter == IW'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient = dvd[Q_W-1:0];

endmodule

// File: rtl/hit_centroid_ctrl.sv
// Per-frame hit accumulator and centroid scheduler for the colour-detection path;
// one shared divider computes X then Y after each vertical sync.
module hit_centroid_ctrl
  import hit_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned SUM_W    = DEF_SUM_W,
  parameter int unsigned MIN_HITS = DEF_MIN_HITS
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iDE,
  input  logic             iVS,
  input  logic             iHIT,
  input  logic             iREADY,
  output logic             oVALID,
  output logic             oFOUND,
  output logic [X_W-1:0]   oX,
  output logic [Y_W-1:0]   oY,
  output logic [CNT_W-1:0] oCOUNT,
  output logic             oBUSY,
  output logic             oERR
);

  localparam int unsigned      Q_W     = max_u(X_W, Y_W);
  localparam logic [X_W:0]     X_END   = (X_W+1)'(H_ACTIVE);
  localparam logic [Y_W:0]     Y_END   = (Y_W+1)'(V_ACTIVE);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_HITS);

  ctrl_state_t      state;
  logic             vs_q, de_q, vs_fall, de_fall, hit_ok;
  logic [X_W:0]     x_pos;
  logic [Y_W:0]     y_pos;
  logic [CNT_W-1:0] cnt, snap_cnt;
  logic [SUM_W-1:0] sum_x, sum_y, snap_sum_y;
  logic [X_W-1:0]   q_x;
  logic             div_start, div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic [Q_W-1:0]   div_quot;

  assign vs_fall = vs_q & ~iVS;
  assign de_fall = de_q & ~iDE;
  assign hit_ok  = iDE & iHIT & (x_pos < X_END) & (y_pos < Y_END);

  // X division reads the live sums during LATCH, Y division the snapshot.
  assign div_start    = ((state == LATCH) && (cnt >= MIN_CNT)) || ((state == DIV_X) && div_done);
  assign div_dividend = (state == LATCH) ? sum_x : snap_sum_y;
  assign div_divisor  = (state == LATCH) ? cnt : snap_cnt;

  seq_udiv #(
    .DVD_W(SUM_W),
    .DVS_W(CNT_W),
    .Q_W  (Q_W)
  ) u_div (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .done    (div_done),
    .quotient(div_quot)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ACCUM;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      x_pos      <= '0;
      y_pos      <= '0;
      cnt        <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      snap_cnt   <= '0;
      snap_sum_y <= '0;
      q_x        <= '0;
      oVALID     <= 1'b0;
      oFOUND     <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oCOUNT     <= '0;
      oBUSY      <= 1'b0;
      oERR       <= 1'b0;
    end else begin
      vs_q <= iVS;
      de_q <= iDE;

      if (!iVS) begin
        x_pos <= '0;
        y_pos <= '0;
      end else if (de_fall) begin
        x_pos <= '0;
        if (y_pos != '1) y_pos <= y_pos + (Y_W+1)'(1);
      end else if (iDE && (x_pos != '1)) begin
        x_pos <= x_pos + (X_W+1)'(1);
      end

      if (hit_ok) begin
        cnt   <= cnt + CNT_W'(1);
        sum_x <= sum_x + SUM_W'(x_pos);
        sum_y <= sum_y + SUM_W'(y_pos);
      end

      // A fresh load below overrides this clear (latest result wins).
      if (oVALID && iREADY) oVALID <= 1'b0;

      unique case (state)
        ACCUM, PRESENT: begin
          if (vs_fall) begin
            state <= LATCH;
            oBUSY <= 1'b1;
          end else begin
            state <= ACCUM;
          end
        end
        LATCH: begin
          snap_cnt   <= cnt;
          snap_sum_y <= sum_y;
          cnt        <= '0;
          sum_x      <= '0;
          sum_y      <= '0;
          if (cnt < MIN_CNT) begin
            oVALID <= 1'b1;
            oFOUND <= 1'b0;
            oX     <= '0;
            oY     <= '0;
            oCOUNT <= cnt;
            oBUSY  <= 1'b0;
            state  <= PRESENT;
          end else begin
            state <= DIV_X;
          end
        end
        DIV_X: begin
          if (div_done) begin
            q_x   <= div_quot[X_W-1:0];
            state <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) begin
            oVALID <= 1'b1;
            oFOUND <= 1'b1;
            oX     <= q_x;
            oY     <= div_quot[Y_W-1:0];
            oCOUNT <= snap_cnt;
            oBUSY  <= 1'b0;
            state  <= PRESENT;
          end
        end
        default: state <= ACCUM;
      endcase

      if (oBUSY && vs_fall) begin
        cnt   <= '0;
        sum_x <= '0;
        sum_y <= '0;
        oERR  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hit_centroid_ctrl.sv
// Directed/randomized frame bench for hit_centroid_ctrl on a reduced 48x24 window
// with a hit-map reference model computing count and floor centroids.
module tb_hit_centroid_ctrl;

  localparam int H      = 48;
  localparam int V      = 24;
  localparam int MINH   = 4;
  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int CW     = 19;
  localparam int SW     = 29;
  localparam int NP     = H + 4;
  localparam int NL     = V + 2;
  localparam int LAT_DIV = 2 * SW + 2;
  localparam int LAT_LOW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          de = 1'b0;
  logic          vs = 1'b1;
  logic          hit = 1'b0;
  logic          ready = 1'b0;
  logic          valid, found, busy, err;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic [CW-1:0] ocount;

  int vectors = 0;
  int miscompares = 0;

  bit hmap [NL][NP];
  int exp_cnt, exp_x, exp_y;
  bit exp_found;

  always #5 clk = ~clk;

  hit_centroid_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .X_W     (XW),
    .Y_W     (YW),
    .CNT_W   (CW),
    .SUM_W   (SW),
    .MIN_HITS(MINH)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .iDE   (de),
    .iVS   (vs),
    .iHIT  (hit),
    .iREADY(ready),
    .oVALID(valid),
    .oFOUND(found),
    .oX    (ox),
    .oY    (oy),
    .oCOUNT(ocount),
    .oBUSY (busy),
    .oERR  (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_map();
    foreach (hmap[l, p]) hmap[l][p] = 1'b0;
  endtask

  task automatic random_map(input int one_in);
    foreach (hmap[l, p]) hmap[l][p] = ($urandom_range(0, one_in - 1) == 0);
  endtask

  task automatic model();
    int sx, sy;
    exp_cnt = 0;
    sx = 0;
    sy = 0;
    for (int l = 0; l < V; l++)
      for (int p = 0; p < H; p++)
        if (hmap[l][p]) begin
          exp_cnt++;
          sx += p;
          sy += l;
        end
    exp_found = (exp_cnt >= MINH);
    exp_x = exp_found ? sx / exp_cnt : 0;
    exp_y = exp_found ? sy / exp_cnt : 0;
  endtask

  task automatic drive_frame();
    for (int l = 0; l < NL; l++) begin
      for (int p = 0; p < NP; p++) begin
        de  = 1'b1;
        hit = hmap[l][p];
        tick();
      end
      de = 1'b0;
      repeat (3) begin
        hit = 1'($urandom_range(0, 1));
        tick();
      end
      hit = 1'b0;
    end
    model();
  endtask

  task automatic check_result(input bit exp_err);
    chk("valid", 32'(valid), 1);
    chk("found", 32'(found), 32'(exp_found));
    chk("x", 32'(ox), exp_x);
    chk("y", 32'(oy), exp_y);
    chk("count", 32'(ocount), exp_cnt);
    chk("busy_done", 32'(busy), 0);
    chk("err", 32'(err), 32'(exp_err));
  endtask

  task automatic end_frame(input bit was_valid, input bit exp_err);
    int lat;
    lat = exp_found ? LAT_DIV : LAT_LOW;
    vs  = 1'b0;
    de  = 1'b0;
    hit = 1'b0;
    for (int t = 1; t <= lat; t++) begin
      tick();
      if (t == 3) vs = 1'b1;
      if (t == 1) chk("busy_latch", 32'(busy), 1);
      if (t == lat - 1) chk("valid_pre", 32'(valid), 32'(was_valid));
    end
    vs = 1'b1;
    check_result(exp_err);
  endtask

  task automatic accept();
    repeat (2) tick();
    chk("hold_valid", 32'(valid), 1);
    chk("hold_x", 32'(ox), exp_x);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("valid_clear", 32'(valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    vs    = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_x", 32'(ox), 0);
    chk("rst_y", 32'(oy), 0);
    chk("rst_count", 32'(ocount), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    // 5x5 square plus hits outside the window
    clear_map();
    for (int l = 10; l < 15; l++)
      for (int p = 20; p < 25; p++) hmap[l][p] = 1'b1;
    hmap[V][5]        = 1'b1;
    hmap[3][H + 1]    = 1'b1;
    hmap[V + 1][H + 2] = 1'b1;
    drive_frame();
    chk("sq_model_cnt", 32'(exp_cnt), 25);
    end_frame(1'b0, 1'b0);
    chk("sq_x_const", 32'(ox), 22);
    chk("sq_y_const", 32'(oy), 12);
    accept();

    // every pixel hit, including outside the window
    foreach (hmap[l, p]) hmap[l][p] = 1'b1;
    drive_frame();
    end_frame(1'b0, 1'b0);
    chk("full_count_const", 32'(ocount), H * V);
    accept();

    // one below threshold
    clear_map();
    hmap[0][0] = 1'b1;
    hmap[0][H - 1] = 1'b1;
    hmap[V - 1][H - 1] = 1'b1;
    drive_frame();
    end_frame(1'b0, 1'b0);
    accept();

    // exactly at threshold: four window corners
    hmap[V - 1][0] = 1'b1;
    drive_frame();
    end_frame(1'b0, 1'b0);
    accept();

    for (int i = 0; i < 3; i++) begin
      random_map(6);
      drive_frame();
      end_frame(1'b0, 1'b0);
      accept();
    end

    // two results without acceptance: latest wins, no error
    random_map(5);
    drive_frame();
    end_frame(1'b0, 1'b0);
    random_map(7);
    drive_frame();
    end_frame(1'b1, 1'b0);
    accept();

    // VS falls again during the X division: frame dropped, error set
    random_map(6);
    drive_frame();
    for (int t = 1; t <= LAT_DIV; t++) begin
      if (t <= 3) begin
        vs = 1'b0; de = 1'b0; hit = 1'b0;
      end else if (t <= 8) begin
        vs = 1'b1; de = 1'b1; hit = 1'b1;
      end else if (t <= 11) begin
        de = 1'b0; hit = 1'b0;
      end else if (t <= 13) begin
        vs = 1'b0;
      end else begin
        vs = 1'b1;
      end
      tick();
      if (t == 11) chk("err_before_drop", 32'(err), 0);
      if (t == 12) chk("err_on_drop", 32'(err), 1);
    end
    vs = 1'b1;
    check_result(1'b1);
    accept();
    repeat (LAT_DIV + 10) tick();
    chk("drop_no_valid", 32'(valid), 0);

    // left pending so the reset below has a visible effect
    random_map(6);
    drive_frame();
    end_frame(1'b0, 1'b1);

    // reset in the middle of the Y division
    random_map(6);
    drive_frame();
    vs = 1'b0;
    for (int t = 1; t <= SW + 10; t++) begin
      tick();
      if (t == 3) vs = 1'b1;
    end
    vs = 1'b1;
    chk("busy_div_y", 32'(busy), 1);
    chk("valid_before_rst", 32'(valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_found", 32'(found), 0);
    chk("mid_rst_x", 32'(ox), 0);
    chk("mid_rst_y", 32'(oy), 0);
    chk("mid_rst_count", 32'(ocount), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT_DIV + 5) tick();
    chk("abandoned_no_valid", 32'(valid), 0);

    random_map(6);
    drive_frame();
    end_frame(1'b0, 1'b0);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
